// File: rtl/systolic_ctrl.sv
// systolic_ctrl: sequencer for an NxN output-stationary systolic PE array.
// One pass per start pulse: clear accumulators, stream k_len operand vectors
// through per-lane diagonal skew registers, wait for the wavefront to drain,
// then pulse done.
// Optional feature macro: SYSTOLIC_CTRL_ABORT_EN adds i_abort, which returns
// an active pass (CLEAR/FEED/DRAIN) to IDLE, flushes the skew pipes and
// re-clears the array without issuing done.
module systolic_ctrl #(
  parameter int unsigned N  = 8,
  parameter int unsigned DW = 8,
  parameter int unsigned KW = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [KW-1:0]     i_k_len,
`ifdef SYSTOLIC_CTRL_ABORT_EN
  input  logic              i_abort,
`endif
  output logic              o_busy,
  output logic              o_done,
  output logic              o_pe_clear,
  output logic              o_rd_en,
  output logic [KW-1:0]     o_rd_addr,
  input  logic [N*DW-1:0]   i_a_rd_data,
  input  logic [N*DW-1:0]   i_x_rd_data,
  output logic [N*DW-1:0]   o_row_weights,
  output logic [N*DW-1:0]   o_col_activations
);

  // Drain covers N-1 further PE hops across each dimension plus accumulate.
  localparam int unsigned      DCW        = $clog2(2 * N + 1);
  localparam logic [DCW-1:0]   DRAIN_LAST = DCW'(2 * N - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_FEED  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t           r_state;
  logic [KW-1:0]    r_k_len;
  logic [DCW-1:0]   r_drain_cnt;
  logic             r_vld;
  logic             w_abort_hit;

  // Abort only acts while a pass is actively using the array.
`ifdef SYSTOLIC_CTRL_ABORT_EN
  assign w_abort_hit = i_abort && ((r_state == S_CLEAR) ||
                                   (r_state == S_FEED)  ||
                                   (r_state == S_DRAIN));
`else
  assign w_abort_hit = 1'b0;
`endif

  // Pass sequencer: state plus all registered control outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_k_len     <= '0;
      r_drain_cnt <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_pe_clear  <= 1'b0;
      o_rd_en     <= 1'b0;
      o_rd_addr   <= '0;
    end else if (w_abort_hit) begin
      r_state     <= S_IDLE;
      r_drain_cnt <= '0;
      o_busy      <= 1'b0;
      o_done      <= 1'b0;
      o_pe_clear  <= 1'b1;
      o_rd_en     <= 1'b0;
    end else begin
      o_done     <= 1'b0;
      o_pe_clear <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_k_len    <= i_k_len;
            r_state    <= S_CLEAR;
            o_busy     <= 1'b1;
            o_pe_clear <= 1'b1;
          end
        end
        S_CLEAR: begin
          if (r_k_len != '0) begin
            r_state   <= S_FEED;
            o_rd_en   <= 1'b1;
            o_rd_addr <= '0;
          end else begin
            r_state <= S_DONE;
            o_done  <= 1'b1;
          end
        end
        S_FEED: begin
          if (o_rd_addr == (r_k_len - KW'(1))) begin
            r_state     <= S_DRAIN;
            o_rd_en     <= 1'b0;
            r_drain_cnt <= '0;
          end else begin
            o_rd_addr <= o_rd_addr + KW'(1);
          end
        end
        S_DRAIN: begin
          if (r_drain_cnt == DRAIN_LAST) begin
            r_state <= S_DONE;
            o_done  <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt + DCW'(1);
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          o_busy  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          o_busy  <= 1'b0;
          o_rd_en <= 1'b0;
        end
      endcase
    end
  end

  // Read data is valid the cycle after the read strobe.
  always_ff @(posedge i_clk) begin
    if (i_rst || w_abort_hit) begin
      r_vld <= 1'b0;
    end else begin
      r_vld <= o_rd_en;
    end
  end

  // Per-lane skew: one capture stage plus 'lane' delay stages; invalid
  // data enters as zero so the array sees zero padding around each pass.
  for (genvar gi = 0; gi < int'(N); gi++) begin : g_lane
    logic [DW-1:0] r_a_sr [0:gi];
    logic [DW-1:0] r_x_sr [0:gi];

    // Capture and shift lane gi of both operand streams.
    always_ff @(posedge i_clk) begin
      if (i_rst || w_abort_hit) begin
        for (int d = 0; d <= gi; d++) begin
          r_a_sr[d] <= '0;
          r_x_sr[d] <= '0;
        end
      end else begin
        r_a_sr[0] <= r_vld ? i_a_rd_data[gi*DW +: DW] : '0;
        r_x_sr[0] <= r_vld ? i_x_rd_data[gi*DW +: DW] : '0;
        for (int d = 1; d <= gi; d++) begin
          r_a_sr[d] <= r_a_sr[d-1];
          r_x_sr[d] <= r_x_sr[d-1];
        end
      end
    end

    assign o_row_weights[gi*DW +: DW]     = r_a_sr[gi];
    assign o_col_activations[gi*DW +: DW] = r_x_sr[gi];
  end

endmodule

// File: tb/tb_systolic_ctrl.sv
// Bench for systolic_ctrl: operand buffer model with one-cycle read latency,
// behavioural 8x8 output-stationary PE array, directed pass scenarios.
module tb_systolic_ctrl;

  localparam int N  = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [7:0]    k_len;
  logic          abort;
  logic          busy, done, pe_clear, rd_en;
  logic [7:0]    rd_addr;
  logic [63:0]   a_rd_data, x_rd_data;
  logic [63:0]   row_weights, col_activations;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] x_off = 8'h00;

  // measurement results of measure_pass
  int m_done_n, m_rden, m_max_addr, m_addr_err, m_pe, m_nz, m_busy_after;

  always #5 clk = ~clk;

  systolic_ctrl dut (
`ifdef SYSTOLIC_CTRL_ABORT_EN
    .i_abort           (abort),
`endif
    .i_clk             (clk),
    .i_rst             (rst),
    .i_start           (start),
    .i_k_len           (k_len),
    .o_busy            (busy),
    .o_done            (done),
    .o_pe_clear        (pe_clear),
    .o_rd_en           (rd_en),
    .o_rd_addr         (rd_addr),
    .i_a_rd_data       (a_rd_data),
    .i_x_rd_data       (x_rd_data),
    .o_row_weights     (row_weights),
    .o_col_activations (col_activations)
  );

  function automatic logic [7:0] a_elem(input int k, input int l);
    return 8'(16 * k + l);
  endfunction

  function automatic logic [7:0] x_elem(input int k, input int l);
    return 8'(16 * k + l + int'(x_off));
  endfunction

  function automatic logic [31:0] golden(input int kl, input int i, input int j);
    logic [31:0] s;
    s = 32'd0;
    for (int k = 0; k < kl; k++) s = s + 32'(a_elem(k, i)) * 32'(x_elem(k, j));
    return s;
  endfunction

  function automatic logic [139:0] all_out();
    return {busy, done, pe_clear, rd_en, rd_addr, row_weights, col_activations};
  endfunction

  // Operand buffers: data for rd_addr appears one cycle after rd_en.
  always @(posedge clk) begin
    if (rd_en) begin
      for (int l = 0; l < N; l++) begin
        a_rd_data[l*DW +: DW] <= a_elem(int'(rd_addr), l);
        x_rd_data[l*DW +: DW] <= x_elem(int'(rd_addr), l);
      end
    end
  end

  // Behavioural PE array, synchronously cleared by pe_clear.
  logic [7:0]  pw   [N][N];
  logic [7:0]  px   [N][N];
  logic [31:0] pacc [N][N];
  always @(posedge clk) begin
    logic [7:0] w_in, x_in;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (j == 0) w_in = row_weights[i*DW +: DW];
        else        w_in = pw[i][j-1];
        if (i == 0) x_in = col_activations[j*DW +: DW];
        else        x_in = px[i-1][j];
        if (pe_clear) begin
          pw[i][j]   <= 8'd0;
          px[i][j]   <= 8'd0;
          pacc[i][j] <= 32'd0;
        end else begin
          pw[i][j]   <= w_in;
          px[i][j]   <= x_in;
          pacc[i][j] <= pacc[i][j] + 32'(w_in) * 32'(x_in);
        end
      end
    end
  end

  // Runs one pass from the current negedge and records what it saw.
  task automatic measure_pass(input int k, input bit hold, input int budget);
    m_done_n = 0; m_rden = 0; m_max_addr = -1; m_addr_err = 0;
    m_pe = 0; m_nz = 0; m_busy_after = 1;
    k_len = 8'(k);
    start = 1'b1;
    @(negedge clk);
    if (!hold) start = 1'b0;
    for (int n = 1; n <= budget; n++) begin
      if (rd_en) begin
        if (int'(rd_addr) != m_rden) m_addr_err++;
        if (int'(rd_addr) > m_max_addr) m_max_addr = int'(rd_addr);
        m_rden++;
      end
      if (pe_clear) m_pe++;
      if (row_weights != 64'd0 || col_activations != 64'd0) m_nz = 1;
      if (done) begin
        m_done_n = n;
        @(negedge clk);
        m_busy_after = int'(busy);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; k_len = 8'd0; abort = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (all_out() !== 140'd0) begin
      n_fail++; $display("FAIL reset_outputs got %h want 0", all_out());
    end
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (all_out() !== 140'd0) begin
      n_fail++; $display("FAIL idle_outputs got %h want 0", all_out());
    end
  endtask

  task automatic test_nominal();
    logic [7:0] ea, ex;
    int k;
    x_off = 8'h00;
    k_len = 8'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int n = 1; n <= 23; n++) begin
      n_checks++;
      if (pe_clear !== (n == 1)) begin
        n_fail++; $display("FAIL nom_pe_clear n=%0d got %b", n, pe_clear);
      end
      n_checks++;
      if (rd_en !== (n >= 2 && n <= 5)) begin
        n_fail++; $display("FAIL nom_rd_en n=%0d got %b", n, rd_en);
      end
      if (n >= 2 && n <= 5) begin
        n_checks++;
        if (rd_addr !== 8'(n - 2)) begin
          n_fail++; $display("FAIL nom_rd_addr n=%0d got %0d want %0d", n, rd_addr, n - 2);
        end
      end
      n_checks++;
      if (done !== (n == 22)) begin
        n_fail++; $display("FAIL nom_done n=%0d got %b", n, done);
      end
      n_checks++;
      if (busy !== (n <= 22)) begin
        n_fail++; $display("FAIL nom_busy n=%0d got %b", n, busy);
      end
      for (int l = 0; l < N; l++) begin
        k = n - 4 - l;
        ea = (k >= 0 && k < 4) ? a_elem(k, l) : 8'd0;
        ex = (k >= 0 && k < 4) ? x_elem(k, l) : 8'd0;
        n_checks++;
        if (row_weights[l*DW +: DW] !== ea) begin
          n_fail++; $display("FAIL nom_row_lane%0d n=%0d got %h want %h", l, n, row_weights[l*DW +: DW], ea);
        end
        n_checks++;
        if (col_activations[l*DW +: DW] !== ex) begin
          n_fail++; $display("FAIL nom_col_lane%0d n=%0d got %h want %h", l, n, col_activations[l*DW +: DW], ex);
        end
      end
      if (n == 22) begin
        for (int i = 0; i < N; i++) begin
          for (int j = 0; j < N; j++) begin
            n_checks++;
            if (pacc[i][j] !== golden(4, i, j)) begin
              n_fail++; $display("FAIL nom_matmul[%0d][%0d] got %0d want %0d", i, j, pacc[i][j], golden(4, i, j));
            end
          end
        end
      end
      if (n < 23) @(negedge clk);
    end
  endtask

  task automatic test_back_to_back();
    measure_pass(255, 1'b0, 300);
    n_checks++;
    if (m_done_n != 273) begin
      n_fail++; $display("FAIL b2b_done_cycle got %0d want 273", m_done_n);
    end
    n_checks++;
    if (m_rden != 255 || m_max_addr != 254 || m_addr_err != 0) begin
      n_fail++; $display("FAIL b2b_reads got cnt=%0d max=%0d err=%0d want 255/254/0", m_rden, m_max_addr, m_addr_err);
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        n_checks++;
        if (pacc[i][j] !== golden(255, i, j)) begin
          n_fail++; $display("FAIL b2b_matmul[%0d][%0d] got %0d want %0d", i, j, pacc[i][j], golden(255, i, j));
        end
      end
    end
  endtask

  task automatic test_zero_len();
    measure_pass(0, 1'b0, 10);
    n_checks++;
    if (m_done_n != 2) begin
      n_fail++; $display("FAIL zero_done_cycle got %0d want 2", m_done_n);
    end
    n_checks++;
    if (m_rden != 0 || m_nz != 0 || m_pe != 1) begin
      n_fail++; $display("FAIL zero_activity got rd=%0d nz=%0d pe=%0d want 0/0/1", m_rden, m_nz, m_pe);
    end
    n_checks++;
    if (m_busy_after != 0) begin
      n_fail++; $display("FAIL zero_busy_after got %0d want 0", m_busy_after);
    end
  endtask

  task automatic test_start_held();
    int second;
    x_off = 8'h80;
    measure_pass(2, 1'b1, 40);
    n_checks++;
    if (m_done_n != 20 || m_rden != 2 || m_pe != 1) begin
      n_fail++; $display("FAIL held_pass got done=%0d rd=%0d pe=%0d want 20/2/1", m_done_n, m_rden, m_pe);
    end
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        n_checks++;
        if (pacc[i][j] !== golden(2, i, j)) begin
          n_fail++; $display("FAIL held_matmul[%0d][%0d] got %0d want %0d", i, j, pacc[i][j], golden(2, i, j));
        end
      end
    end
    n_checks++;
    if (m_busy_after != 0) begin
      n_fail++; $display("FAIL held_idle_gap got busy=%0d want 0", m_busy_after);
    end
    @(negedge clk);
    n_checks++;
    if (busy !== 1'b1 || pe_clear !== 1'b1) begin
      n_fail++; $display("FAIL held_second_start got busy=%b pe_clear=%b want 1/1", busy, pe_clear);
    end
    start = 1'b0;
    second = 0;
    for (int n = 2; n <= 40; n++) begin
      @(negedge clk);
      if (done) begin second = n; break; end
    end
    n_checks++;
    if (second != 20) begin
      n_fail++; $display("FAIL held_second_done got %0d want 20", second);
    end
    @(negedge clk);
    x_off = 8'h00;
  endtask

  task automatic test_reset_mid_feed();
    int seen;
    k_len = 8'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if (rd_en !== 1'b1 || rd_addr !== 8'd2) begin
      n_fail++; $display("FAIL rmf_in_feed got rd_en=%b addr=%0d want 1/2", rd_en, rd_addr);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_checks++;
    if (all_out() !== 140'd0) begin
      n_fail++; $display("FAIL rmf_after_reset got %h want 0", all_out());
    end
    seen = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done || busy || row_weights != 64'd0 || col_activations != 64'd0) seen = 1;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++; $display("FAIL rmf_quiet got activity=%0d want 0", seen);
    end
    measure_pass(3, 1'b0, 40);
    n_checks++;
    if (m_done_n != 21 || m_rden != 3 || m_addr_err != 0) begin
      n_fail++; $display("FAIL rmf_next_pass got done=%0d rd=%0d err=%0d want 21/3/0", m_done_n, m_rden, m_addr_err);
    end
  endtask

`ifdef SYSTOLIC_CTRL_ABORT_EN
  task automatic test_abort();
    int seen;
    k_len = 8'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_checks++;
    if (busy !== 1'b0 || rd_en !== 1'b0 || pe_clear !== 1'b1 || done !== 1'b0) begin
      n_fail++; $display("FAIL abort_ctrl got busy=%b rd_en=%b pe_clear=%b done=%b want 0/0/1/0", busy, rd_en, pe_clear, done);
    end
    n_checks++;
    if (row_weights !== 64'd0 || col_activations !== 64'd0) begin
      n_fail++; $display("FAIL abort_lanes got %h %h want 0", row_weights, col_activations);
    end
    seen = 0;
    for (int n = 0; n < 30; n++) begin
      @(negedge clk);
      if (done || busy || pe_clear || row_weights != 64'd0 || col_activations != 64'd0) seen = 1;
    end
    n_checks++;
    if (seen != 0) begin
      n_fail++; $display("FAIL abort_quiet got activity=%0d want 0", seen);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_nominal();
    test_back_to_back();
    test_zero_len();
    test_start_held();
    test_reset_mid_feed();
`ifdef SYSTOLIC_CTRL_ABORT_EN
    test_abort();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
